// File: rtl/bullet_pool.sv
// Pool of enemy-bullet slots: lowest-free-slot spawn allocation, per-slot fall speed,
// retire or wrap at the floor, and two independent combinational read ports.
module bullet_pool #(
   parameter int NUM_SLOTS = 8,
   parameter int IDX_W     = 3,
   parameter int COORD_W   = 8,
   parameter int VY_W      = 4,
   parameter int Y_LIMIT   = 200,
   parameter int WRAP_MODE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 clear,
   input  logic                 spawn_valid,
   output logic                 spawn_ready,
   input  logic [COORD_W-1:0]   spawn_x,
   input  logic [COORD_W-1:0]   spawn_y,
   input  logic [COORD_W-1:0]   spawn_w,
   input  logic [COORD_W-1:0]   spawn_h,
   input  logic [2:0]           spawn_color,
   input  logic [VY_W-1:0]      spawn_vy,
   output logic [IDX_W-1:0]     spawn_slot,
   output logic [IDX_W:0]       active_count,
   input  logic [IDX_W-1:0]     index1,
   input  logic [IDX_W-1:0]     index2,
   output logic [2*COORD_W-1:0] position1,
   output logic [2*COORD_W-1:0] size1,
   output logic [2:0]           color1,
   output logic                 isRender1,
   output logic [2*COORD_W-1:0] position2,
   output logic [2*COORD_W-1:0] size2,
   output logic [2:0]           color2,
   output logic                 isRender2
);

   localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(Y_LIMIT);

   logic [COORD_W-1:0] x_q     [NUM_SLOTS];
   logic [COORD_W-1:0] y_q     [NUM_SLOTS];
   logic [COORD_W-1:0] w_q     [NUM_SLOTS];
   logic [COORD_W-1:0] h_q     [NUM_SLOTS];
   logic [2:0]         color_q [NUM_SLOTS];
   logic [VY_W-1:0]    vy_q    [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] active_q;
   logic [IDX_W:0]       count_q;

   logic [COORD_W-1:0]   y_next [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] load;
   logic [NUM_SLOTS-1:0] move;
   logic [NUM_SLOTS-1:0] retire;
   logic [NUM_SLOTS-1:0] active_d;
   logic [IDX_W:0]       count_d;
   logic                 free_found;
   logic                 spawn_fire;

   function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] y,
                                                  input logic [VY_W-1:0]    vy);
      logic [COORD_W:0] sum;
      sum = {1'b0, y} + (COORD_W+1)'(vy);
      return sum[COORD_W] ? {COORD_W{1'b1}} : sum[COORD_W-1:0];
   endfunction

   // Lowest inactive slot; depends only on registered active flags.
   always_comb begin
      spawn_slot = '0;
      free_found = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!active_q[i] && !free_found) begin
            spawn_slot = IDX_W'(i);
            free_found = 1'b1;
         end
      end
   end

   // Spawn handshake: a request transfers on a rising edge where spawn_valid && spawn_ready;
   // spawn_ready never looks at spawn_valid, and the request is simply ignored otherwise.
   assign spawn_ready = free_found && !clear;
   assign spawn_fire  = spawn_valid && spawn_ready;

   always_comb begin
      load   = '0;
      move   = '0;
      retire = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         y_next[i] = y_q[i];
         if (spawn_fire && spawn_slot == IDX_W'(i)) begin
            load[i] = 1'b1;
         end else if (tick && !clear && active_q[i]) begin
            if ({1'b0, y_q[i]} >= Y_LIM) begin
               if (WRAP_MODE != 0) begin
                  move[i]   = 1'b1;
                  y_next[i] = COORD_W'(1);
               end else begin
                  retire[i] = 1'b1;
               end
            end else begin
               move[i]   = 1'b1;
               y_next[i] = sat_add(y_q[i], vy_q[i]);
            end
         end
      end
   end

   // A retiring slot is not in load (it was active), so it cannot be refilled this cycle.
   always_comb begin
      active_d = clear ? '0 : ((active_q | load) & ~retire);
      count_d  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         count_d = count_d + (IDX_W+1)'(active_d[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            x_q[i]     <= '0;
            y_q[i]     <= '0;
            w_q[i]     <= '0;
            h_q[i]     <= '0;
            color_q[i] <= '0;
            vy_q[i]    <= '0;
         end
         active_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (load[i]) begin
               x_q[i]     <= spawn_x;
               y_q[i]     <= spawn_y;
               w_q[i]     <= spawn_w;
               h_q[i]     <= spawn_h;
               color_q[i] <= spawn_color;
               vy_q[i]    <= spawn_vy;
            end else if (move[i]) begin
               y_q[i] <= y_next[i];
            end
         end
         active_q <= active_d;
         count_q  <= count_d;
      end
   end

   assign active_count = count_q;

   // Out-of-range indices match no slot and so read as zero.
   always_comb begin
      position1 = '0;
      size1     = '0;
      color1    = '0;
      isRender1 = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (index1 == IDX_W'(i)) begin
            position1 = {x_q[i], y_q[i]};
            size1     = {w_q[i], h_q[i]};
            color1    = color_q[i];
            isRender1 = active_q[i];
         end
      end
   end

   always_comb begin
      position2 = '0;
      size2     = '0;
      color2    = '0;
      isRender2 = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (index2 == IDX_W'(i)) begin
            position2 = {x_q[i], y_q[i]};
            size2     = {w_q[i], h_q[i]};
            color2    = color_q[i];
            isRender2 = active_q[i];
         end
      end
   end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: a 6-slot wrapping pool (index 0) and an 8-slot retiring pool (index 1).
module tb_bullet_pool;

   logic clk = 1'b0;
   logic rst;

   logic       tick [2];
   logic       clear [2];
   logic       sv [2];
   logic [7:0] sx [2];
   logic [7:0] sy [2];
   logic [7:0] sw [2];
   logic [7:0] sh [2];
   logic [2:0] sc [2];
   logic [3:0] svy [2];
   logic [2:0] i1 [2];
   logic [2:0] i2 [2];

   logic        rdy [2];
   logic [2:0]  slot [2];
   logic [3:0]  cnt [2];
   logic [15:0] p1 [2];
   logic [15:0] s1 [2];
   logic [15:0] p2 [2];
   logic [15:0] s2 [2];
   logic [2:0]  c1 [2];
   logic [2:0]  c2 [2];
   logic        r1 [2];
   logic        r2 [2];

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   bullet_pool #(.NUM_SLOTS(6), .IDX_W(3), .COORD_W(8), .VY_W(4), .Y_LIMIT(200), .WRAP_MODE(1)) u_wrap (
      .clk(clk), .reset(rst), .tick(tick[0]), .clear(clear[0]),
      .spawn_valid(sv[0]), .spawn_ready(rdy[0]),
      .spawn_x(sx[0]), .spawn_y(sy[0]), .spawn_w(sw[0]), .spawn_h(sh[0]),
      .spawn_color(sc[0]), .spawn_vy(svy[0]), .spawn_slot(slot[0]), .active_count(cnt[0]),
      .index1(i1[0]), .index2(i2[0]),
      .position1(p1[0]), .size1(s1[0]), .color1(c1[0]), .isRender1(r1[0]),
      .position2(p2[0]), .size2(s2[0]), .color2(c2[0]), .isRender2(r2[0])
   );

   bullet_pool #(.NUM_SLOTS(8), .IDX_W(3), .COORD_W(8), .VY_W(4), .Y_LIMIT(200), .WRAP_MODE(0)) u_ret (
      .clk(clk), .reset(rst), .tick(tick[1]), .clear(clear[1]),
      .spawn_valid(sv[1]), .spawn_ready(rdy[1]),
      .spawn_x(sx[1]), .spawn_y(sy[1]), .spawn_w(sw[1]), .spawn_h(sh[1]),
      .spawn_color(sc[1]), .spawn_vy(svy[1]), .spawn_slot(slot[1]), .active_count(cnt[1]),
      .index1(i1[1]), .index2(i2[1]),
      .position1(p1[1]), .size1(s1[1]), .color1(c1[1]), .isRender1(r1[1]),
      .position2(p2[1]), .size2(s2[1]), .color2(c2[1]), .isRender2(r2[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      for (int d = 0; d < 2; d++) begin
         tick[d] = 1'b0; clear[d] = 1'b0; sv[d] = 1'b0;
         sx[d] = '0; sy[d] = '0; sw[d] = '0; sh[d] = '0;
         sc[d] = '0; svy[d] = '0; i1[d] = '0; i2[d] = '0;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic spawn(input int d, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] w, input logic [7:0] h,
                        input logic [2:0] c, input logic [3:0] vy, input logic tk);
      sx[d] = x; sy[d] = y; sw[d] = w; sh[d] = h; sc[d] = c; svy[d] = vy;
      sv[d] = 1'b1; tick[d] = tk;
      @(posedge clk);
      #1 sv[d] = 1'b0; tick[d] = 1'b0;
   endtask

   task automatic pulse_tick(input int d);
      tick[d] = 1'b1;
      @(posedge clk);
      #1 tick[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      apply_reset();

      // Reset state on both pools
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_count%0d", d), cnt[d], 0);
         check($sformatf("rst_ready%0d", d), rdy[d], 1);
         check($sformatf("rst_slot%0d", d), slot[d], 0);
         check($sformatf("rst_pos%0d", d), p1[d], 0);
         check($sformatf("rst_render%0d", d), r1[d], 0);
      end

      // Basic spawn into slot 0
      spawn(1, 8'd36, 8'd19, 8'd16, 8'd16, 3'b001, 4'd5, 1'b0);
      check("spawn_pos", p1[1], 16'h2413);
      check("spawn_size", s1[1], 16'h1010);
      check("spawn_color", c1[1], 3'b001);
      check("spawn_render", r1[1], 1);
      check("spawn_count", cnt[1], 1);
      check("spawn_slot", slot[1], 1);

      // Wrap at the floor: 195 -> 200 -> 1 -> 6
      apply_reset();
      spawn(0, 8'd20, 8'd195, 8'd4, 8'd4, 3'b010, 4'd5, 1'b0);
      exp_q.push_back(8'd200);
      exp_q.push_back(8'd1);
      exp_q.push_back(8'd6);
      for (int k = 0; k < 3; k++) begin
         pulse_tick(0);
         check($sformatf("wrap_y%0d", k), p1[0][7:0], exp_q.pop_front());
         check($sformatf("wrap_render%0d", k), r1[0], 1);
      end
      check("wrap_count", cnt[0], 1);

      // Retire at the floor
      apply_reset();
      spawn(1, 8'd10, 8'd195, 8'd4, 8'd4, 3'b010, 4'd5, 1'b0);
      pulse_tick(1);
      check("ret_y", p1[1][7:0], 200);
      check("ret_render_before", r1[1], 1);
      check("ret_slot_busy", slot[1], 1);
      pulse_tick(1);
      check("ret_render_after", r1[1], 0);
      check("ret_count", cnt[1], 0);
      check("ret_y_held", p1[1][7:0], 200);
      check("ret_slot_free", slot[1], 0);

      // Fill all eight slots; slot 3 sits on the floor
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         check($sformatf("fill_slot%0d", k), slot[1], k);
         spawn(1, 8'(k + 1), (k == 3) ? 8'd200 : 8'd10, 8'd2, 8'd2, 3'b000, 4'd0, 1'b0);
      end
      check("full_ready", rdy[1], 0);
      check("full_count", cnt[1], 8);
      spawn(1, 8'd99, 8'd99, 8'd99, 8'd99, 3'b111, 4'd7, 1'b0);
      check("full_ignore_count", cnt[1], 8);
      check("full_ignore_x", p1[1][15:8], 1);
      pulse_tick(1);
      check("free3_slot", slot[1], 3);
      check("free3_count", cnt[1], 7);
      check("free3_ready", rdy[1], 1);
      i2[1] = 3'd4;
      #1 check("others_unmoved", p2[1], 16'h050A);

      // Clear with a simultaneous spawn request
      clear[1] = 1'b1;
      sx[1] = 8'd77; sy[1] = 8'd77; sv[1] = 1'b1;
      #1 check("clear_ready_low", rdy[1], 0);
      @(posedge clk);
      #1 clear[1] = 1'b0; sv[1] = 1'b0;
      check("clear_count", cnt[1], 0);
      for (int k = 0; k < 8; k++) begin
         i1[1] = 3'(k);
         #1 check($sformatf("clear_render%0d", k), r1[1], 0);
      end
      i1[1] = 3'd3;
      #1 check("clear_no_load", p1[1][15:8], 4);
      check("clear_slot", slot[1], 0);

      // Spawn and tick in the same cycle
      apply_reset();
      spawn(0, 8'd1, 8'd10, 8'd3, 8'd3, 3'b000, 4'd4, 1'b0);
      spawn(0, 8'd2, 8'd50, 8'd3, 8'd3, 3'b000, 4'd3, 1'b1);
      i1[0] = 3'd0; i2[0] = 3'd1;
      #1 check("both_slot0_y", p1[0][7:0], 14);
      check("both_slot1_y", p2[0][7:0], 50);
      check("both_count", cnt[0], 2);

      // Independent read ports and out-of-range index
      spawn(0, 8'd3, 8'd30, 8'd8, 8'd9, 3'b010, 4'd0, 1'b0);
      spawn(0, 8'd4, 8'd40, 8'd1, 8'd1, 3'b000, 4'd0, 1'b0);
      spawn(0, 8'd5, 8'd60, 8'd1, 8'd1, 3'b000, 4'd0, 1'b0);
      spawn(0, 8'd6, 8'd70, 8'd5, 8'd6, 3'b001, 4'd0, 1'b0);
      i1[0] = 3'd2; i2[0] = 3'd5;
      #1 check("port1_size", s1[0], 16'h0809);
      check("port1_color", c1[0], 3'b010);
      check("port2_size", s2[0], 16'h0506);
      check("port2_color", c2[0], 3'b001);
      check("pool6_full", rdy[0], 0);
      i1[0] = 3'd7;
      #1 check("oob_pos", p1[0], 0);
      check("oob_size", s1[0], 0);
      check("oob_color", c1[0], 0);
      check("oob_render", r1[0], 0);

      // Asynchronous reset mid-operation, away from a clock edge
      @(negedge clk);
      rst = 1'b1;
      #1 check("async_rst_count", cnt[0], 0);
      i1[0] = 3'd2;
      #1 check("async_rst_pos", p1[0], 0);
      @(posedge clk);
      #1 rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
